// File: rtl/ram_loader_pkg.sv
// ---------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the RAM loader slice.
//   - FSM state encodings (IDLE, LOAD, DONE) as plain logic constants so the
//     encoding stays readable in older tools and waveform viewers.
//   - bytesPerWord(): number of received bytes needed to fill one RAM word.
// ---------------------------------------------------------------------------
package ram_loader_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Round up so a partial top byte still gets its own slot.
  function automatic int bytesPerWord(input int dataWidth);
    return (dataWidth + 7) / 8;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// ---------------------------------------------------------------------------
// ram_loader_if
// Groups the serial byte stream feeding the loader and the RAM write bus it
// drives.
//   rxValid  : byte valid this cycle (from the serial receiver)
//   rxData   : received byte
//   wrEn     : RAM write enable, one cycle per word
//   address  : RAM word address
//   dataOut  : word presented to RAM dataIn
// Modports:
//   master : the loader (consumes the stream, drives the RAM bus)
//   slave  : the environment (receiver + RAM)
// ---------------------------------------------------------------------------
interface ram_loader_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
);

  logic                  rxValid;
  logic [7:0]            rxData;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataOut;

  modport master (
    input  rxValid,
    input  rxData,
    output wrEn,
    output address,
    output dataOut
  );

  modport slave (
    output rxValid,
    output rxData,
    input  wrEn,
    input  address,
    input  dataOut
  );

endinterface

// File: rtl/ram_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs a little-endian byte stream into DATA_WIDTH-bit words. The first
// byte of a word lands in bits [7:0]; bits of the last byte above
// DATA_WIDTH-1 are dropped.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : restart packing at slot 0 (new load)
//   i_byteValid   : a byte is consumed this cycle
//   i_byte        : the byte
//   o_lastByte    : combinational, this cycle's byte completes a word
//   o_wordValid   : registered, one-cycle pulse the cycle after completion
//   o_word        : registered, last completed word (held between words)
// ---------------------------------------------------------------------------
module byte_packer #(
  parameter int DATA_WIDTH     = 12,
  parameter int BYTES_PER_WORD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_byteValid,
  input  logic [7:0]            i_byte,
  output logic                  o_lastByte,
  output logic                  o_wordValid,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam int SLOT_BITS = BYTES_PER_WORD * 8;
  localparam int CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);

  logic [SLOT_BITS-1:0] r_slots;
  logic [CNT_W-1:0]     r_byteCnt;
  logic                 r_wordValid;
  logic [DATA_WIDTH-1:0] r_word;
  logic [SLOT_BITS-1:0] w_nextSlots;
  logic                 w_lastByte;

  // Slot image including the incoming byte, so the completed word can be
  // captured on the same edge the final byte arrives (one cycle latency).
  always_comb begin
    w_nextSlots = r_slots;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (r_byteCnt == CNT_W'(i)) begin
        w_nextSlots[i*8 +: 8] = i_byte;
      end
    end
  end

  assign w_lastByte = i_byteValid && (r_byteCnt == LAST_SLOT);

  // A byte accepted while the previous word is being written simply starts
  // the next word, so the stream never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slots     <= '0;
      r_byteCnt   <= '0;
      r_wordValid <= 1'b0;
      r_word      <= '0;
    end else if (i_clear) begin
      r_byteCnt   <= '0;
      r_wordValid <= 1'b0;
    end else begin
      r_wordValid <= w_lastByte;
      if (i_byteValid) begin
        r_slots   <= w_nextSlots;
        r_byteCnt <= w_lastByte ? '0 : r_byteCnt + 1'b1;
      end
      if (w_lastByte) begin
        r_word <= w_nextSlots[DATA_WIDTH-1:0];
      end
    end
  end

  assign o_lastByte  = w_lastByte;
  assign o_wordValid = r_wordValid;
  assign o_word      = r_word;

endmodule

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
// Loads DEPTH words into the single-port data/instruction RAM from the
// serial byte stream, writing consecutive addresses from 0, then flags
// completion so the cores can be released. Accepts one byte per clock with
// no backpressure.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_start  : single-cycle pulse, begins a load from address 0
//   bus      : ram_loader_if.master (rxValid/rxData in, wrEn/address/dataOut out)
//   o_busy   : high while loading
//   o_done   : high after the last word is written, until the next start
// ---------------------------------------------------------------------------
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 12,
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int BYTES_PER_WORD = bytesPerWord(DATA_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  ram_loader_if.master      bus,
  output logic              o_busy,
  output logic              o_done
);

  // Word index carries one extra bit so a power-of-two DEPTH reaches the
  // limit instead of wrapping back to 0.
  localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH:0]   r_wordIdx;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_loading;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_lastByte;
  logic                  w_wordValid;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_loading = (r_state == LOAD);
  // Bytes after the final word (e.g. during its write cycle) are ignored.
  assign w_accept  = w_loading && bus.rxValid && (r_wordIdx < WORD_LIMIT);
  // start is only honoured outside LOAD, so only then restart the packer.
  assign w_clear   = i_start && !w_loading;

  byte_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_byteValid (w_accept),
    .i_byte      (bus.rxData),
    .o_lastByte  (w_lastByte),
    .o_wordValid (w_wordValid),
    .o_word      (w_word)
  );

  // Control FSM and address counter. The address register updates on the
  // same edge the packer registers the word, so wrEn/address/dataOut line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wordIdx <= '0;
      r_address <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state   <= LOAD;
            r_wordIdx <= '0;
            r_address <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        LOAD: begin
          if (w_lastByte) begin
            r_address <= r_wordIdx[ADDR_WIDTH-1:0];
            r_wordIdx <= r_wordIdx + 1'b1;
          end
          // Finish on the write cycle of the last word.
          if (w_wordValid && (r_wordIdx == WORD_LIMIT)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wrEn    = w_wordValid;
  assign bus.address = r_address;
  assign bus.dataOut = w_word;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
// Directed bench for ram_loader driving a behavioural RAM; expected words
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ram_loader;

  localparam int DATA_WIDTH = 12;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  ram_loader_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus();

  ram_loader #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .bus     (bus.master),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM written by the loader
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.wrEn) ram[bus.address] <= bus.dataOut;
  end

  // Write monitor: logs every wrEn pulse with its cycle and address
  int   cycle = 0;
  int   wrCount = 0;
  int   consecPulses = 0;
  logic prevWr = 1'b0;
  int   wrCycle [256];
  int   wrAddrLog [256];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (bus.wrEn === 1'b1) begin
      wrCycle[wrCount % 256]   <= cycle;
      wrAddrLog[wrCount % 256] <= int'(bus.address);
      wrCount                  <= wrCount + 1;
      if (prevWr) consecPulses <= consecPulses + 1;
    end
    prevWr <= (bus.wrEn === 1'b1);
  end

  int errorCount = 0;
  int checkCount = 0;

  logic [7:0]            patA [16];
  logic [DATA_WIDTH-1:0] expA [DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    start = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One byte on the stream, followed by 0..gapMax idle cycles
  task automatic applyStimulus(input logic [7:0] b, input int gapMax);
    bus.rxValid = 1'b1;
    bus.rxData  = b;
    tick();
    bus.rxValid = 1'b0;
    if (gapMax > 0) repeat ($urandom_range(0, gapMax)) tick();
  endtask

  task automatic loadPatternA(input int gapMax);
    for (int i = 0; i < 16; i++) applyStimulus(patA[i], gapMax);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic checkRam(input string tag);
    for (int i = 0; i < DEPTH; i++) checkOutput(tag, 32'(ram[i]), 32'(expA[i]));
  endtask

  initial begin
    int base;
    int gapErr;
    int addrErr;

    patA = '{8'hFF, 8'hFF, 8'h34, 8'h12, 8'h01, 8'h00, 8'hCD, 8'h0A,
             8'h55, 8'h05, 8'h00, 8'h0F, 8'h78, 8'h06, 8'h9A, 8'h0B};
    expA = '{12'hFFF, 12'h234, 12'h001, 12'hACD,
             12'h555, 12'hF00, 12'h678, 12'hB9A};

    rst = 1'b1;
    start = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData = 8'h00;
    #2;
    checkOutput("rstWrEn",    32'(bus.wrEn),    32'd0);
    checkOutput("rstAddress", 32'(bus.address), 32'd0);
    checkOutput("rstDataOut", 32'(bus.dataOut), 32'd0);
    checkOutput("rstBusy",    32'(busy),        32'd0);
    checkOutput("rstDone",    32'(done),        32'd0);
    applyReset();

    // First word: 0x64,0x00 -> 0x064 at address 0
    pulseStart();
    checkOutput("startBusy", 32'(busy), 32'd1);
    applyStimulus(8'h64, 0);
    applyStimulus(8'h00, 0);
    checkOutput("firstWrEn",    32'(bus.wrEn),    32'd1);
    checkOutput("firstAddress", 32'(bus.address), 32'd0);
    checkOutput("firstDataOut", 32'(bus.dataOut), 32'h064);
    checkOutput("firstBusy",    32'(busy),        32'd1);
    checkOutput("firstDone",    32'(done),        32'd0);
    tick();
    checkOutput("firstWrEnOnce", 32'(bus.wrEn), 32'd0);

    // Back-to-back full load
    applyReset();
    pulseStart();
    base = wrCount;
    loadPatternA(0);
    checkOutput("b2bLastWrEn",    32'(bus.wrEn),    32'd1);
    checkOutput("b2bLastAddress", 32'(bus.address), 32'd7);
    checkOutput("b2bNotDoneYet",  32'(done),        32'd0);
    tick();
    checkOutput("b2bDone", 32'(done), 32'd1);
    checkOutput("b2bBusy", 32'(busy), 32'd0);
    checkOutput("b2bPulses", 32'(wrCount - base), 32'd8);
    gapErr = 0;
    addrErr = 0;
    for (int k = 0; k < 8; k++) begin
      if (wrAddrLog[(base + k) % 256] != k) addrErr++;
      if (k > 0 && wrCycle[(base + k) % 256] - wrCycle[(base + k - 1) % 256] != 2) gapErr++;
    end
    checkOutput("b2bAddrOrder", 32'(addrErr), 32'd0);
    checkOutput("b2bEverySecond", 32'(gapErr), 32'd0);
    checkRam("b2bRam");

    // Random gaps, started from DONE
    pulseStart();
    checkOutput("gapRestartDone", 32'(done), 32'd0);
    base = wrCount;
    loadPatternA(5);
    waitDone("gapDone");
    checkOutput("gapPulses", 32'(wrCount - base), 32'd8);
    checkRam("gapRam");

    // Bytes in DONE are ignored; start resumes at address 0
    base = wrCount;
    repeat (4) applyStimulus(8'hAA, 0);
    tick();
    checkOutput("doneIgnoreWr", 32'(wrCount - base), 32'd0);
    checkOutput("doneHeld",     32'(done),           32'd1);
    pulseStart();
    checkOutput("reloadBusy", 32'(busy), 32'd1);
    checkOutput("reloadDone", 32'(done), 32'd0);
    applyStimulus(8'h64, 0);
    applyStimulus(8'h00, 0);
    checkOutput("reloadWrEn",    32'(bus.wrEn),    32'd1);
    checkOutput("reloadAddress", 32'(bus.address), 32'd0);
    checkOutput("reloadDataOut", 32'(bus.dataOut), 32'h064);

    // Reset with word 2 half filled
    applyReset();
    pulseStart();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h33, 0);
    rst = 1'b1;
    #1;
    checkOutput("midRstWrEn",    32'(bus.wrEn),    32'd0);
    checkOutput("midRstAddress", 32'(bus.address), 32'd0);
    checkOutput("midRstDataOut", 32'(bus.dataOut), 32'd0);
    checkOutput("midRstBusy",    32'(busy),        32'd0);
    checkOutput("midRstDone",    32'(done),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("midRstRam0", 32'(ram[0]), 32'h111);
    checkOutput("midRstRam1", 32'(ram[1]), 32'h222);
    checkOutput("midRstRam2", 32'(ram[2]), 32'h001);
    pulseStart();
    loadPatternA(3);
    waitDone("afterRstDone");
    checkRam("afterRstRam");

    // start mid-LOAD after 3 words is ignored
    pulseStart();
    base = wrCount;
    for (int i = 0; i < 6; i++) applyStimulus(patA[i], 0);
    start = 1'b1;
    applyStimulus(patA[6], 0);
    start = 1'b0;
    for (int i = 7; i < 16; i++) applyStimulus(patA[i], 0);
    waitDone("midStartDone");
    checkOutput("midStartPulses",   32'(wrCount - base), 32'd8);
    checkOutput("midStartLastAddr", 32'(wrAddrLog[(base + 7) % 256]), 32'd7);
    checkRam("midStartRam");

    checkOutput("noConsecWrEn", 32'(consecPulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
